// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths and FSM state type for the ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned RESULT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. last_grant = 1 means requester 1 was
// served last, so requester 0 wins a tie.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; a lone requester wins regardless of history.
  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared ALU and returns the
// result to the granted requester. Defining ALU_ARB_TIMEOUT_EN bounds the WAIT
// state to TIMEOUT_CYCLES cycles and reports an abort through rsp_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [OPCODE_W-1:0] op0,
  input  logic [OPCODE_W-1:0] op1,
  input  logic [DATA_W-1:0]   a0,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   b0,
  input  logic [DATA_W-1:0]   b1,
  output logic                ack0,
  output logic                ack1,
  output logic                rsp_valid0,
  output logic                rsp_valid1,
  output logic [RESULT_W-1:0] rsp_result,
  output logic                rsp_cout,
  output logic                rsp_err,
  output logic                alu_go,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [RESULT_W-1:0] alu_result,
  input  logic                alu_cout,
  input  logic                alu_done,
  output logic                busy
);

  state_t     state, state_nxt;
  logic       owner;     // requester currently/last served (1 = requester 1)
  logic [1:0] grant;
  logic       seen_low;  // alu_done observed low since ISSUE
  logic       accept;
  logic       timeout;

  rr_arb2 u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (owner),
    .grant      (grant)
  );

  // A done level left over from the previous operation must not complete this one.
  assign accept = (state == WAIT) && alu_done && seen_low;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nxt  = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    alu_go     = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0 || req1) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_go    = 1'b1;
        ack0      = !owner;
        ack1      = owner;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (accept || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid0 = !owner;
        rsp_valid1 = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, stale-done tracking and response latching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b1;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      seen_low   <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      if (state == IDLE && grant != 2'b00) begin
        owner      <= grant[1];
        alu_opcode <= grant[1] ? op1 : op0;
        alu_a      <= grant[1] ? a1 : a0;
        alu_b      <= grant[1] ? b1 : b0;
      end
      if (state == IDLE) begin
        seen_low <= 1'b0;
      end else if (!alu_done) begin
        seen_low <= 1'b1;
      end
      if (accept) begin
        rsp_result <= alu_result;
        rsp_cout   <= alu_cout;
      end else if (timeout) begin
        rsp_result <= '0;
        rsp_cout   <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_r;

  // The last counted WAIT cycle forces RESP unless a done is accepted in it.
  assign timeout = (state == WAIT) && !accept && (32'(wait_cnt) == TIMEOUT_CYCLES - 1);
  assign rsp_err = (state == RESP) && err_r;

  // WAIT cycle counter, cleared outside WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Records whether the pending response is an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (accept) begin
      err_r <= 1'b0;
    end else if (timeout) begin
      err_r <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
